arbitro_memoria: RTL and testbench

- Shares the single memory port between the CPU control unit's fetch/DR/AR accesses and an I/O-DMA requester.
- Serializes one transaction at a time and inserts LATENCIA memory wait cycles.
- Latches the read data and returns a one-cycle listo pulse to the winning requester.
- Sits between the control unit/datapath and the memory.

---
 rtl/arbitro_memoria.sv | 187 ++++++++++++++++++
 tb/tb_arbitro_memoria.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - single memory port arbiter between CPU and I/O-DMA requesters
//
// Purpose:
//    Serializes CPU and I/O-DMA accesses onto one memory port. A grant in REPOSO
//    latches the winner's address, write data and direction; mem_en is then held
//    for LATENCIA cycles (ACCESO), read data is captured on the last of them, and
//    the winner receives a one-cycle listo pulse in FIN.
//
// Ports:
//    Reloj, Reiniciar          clock (rising edge), asynchronous active-low reset
//    cpu_req/we/dir/dato_w     CPU request, held until cpu_listo
//    cpu_bloqueo               CPU bus lock, keeps I/O out between CPU accesses
//    cpu_dato_r, cpu_listo     CPU read data (held) and completion pulse
//    io_req/we/dir/dato_w      I/O request, held until io_listo
//    io_dato_r, io_listo       I/O read data (held) and completion pulse
//    mem_en/we/dir/dato_w      memory command, stable for the whole access
//    mem_dato_r                memory read data
//    ocupado                   high whenever the arbiter is not in REPOSO
//
// Build option:
//    ARBITRO_ROUND_ROBIN_EN    defined: simultaneous eligible requests alternate;
//                              undefined: fixed CPU > I/O priority.

module arbitro_memoria #(
   parameter int ANCHO_DIR  = 16,
   parameter int ANCHO_DATO = 16,
   parameter int LATENCIA   = 2
) (
   input  logic                  Reloj,
   input  logic                  Reiniciar,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ANCHO_DIR-1:0]  cpu_dir,
   input  logic [ANCHO_DATO-1:0] cpu_dato_w,
   input  logic                  cpu_bloqueo,
   output logic [ANCHO_DATO-1:0] cpu_dato_r,
   output logic                  cpu_listo,
   input  logic                  io_req,
   input  logic                  io_we,
   input  logic [ANCHO_DIR-1:0]  io_dir,
   input  logic [ANCHO_DATO-1:0] io_dato_w,
   output logic [ANCHO_DATO-1:0] io_dato_r,
   output logic                  io_listo,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ANCHO_DIR-1:0]  mem_dir,
   output logic [ANCHO_DATO-1:0] mem_dato_w,
   input  logic [ANCHO_DATO-1:0] mem_dato_r,
   output logic                  ocupado
);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      ACCESO = 2'd1,
      FIN    = 2'd2
   } estado_t;

   localparam logic       GANA_CPU     = 1'b0;
   localparam logic       GANA_IO      = 1'b1;
   localparam logic [3:0] CONTADOR_INI = 4'(LATENCIA - 1);

   estado_t               estado_q, estado_d;
   logic [3:0]            contador_q, contador_d;
   logic                  ganador_q, ganador_d;
   logic                  bloqueo_q, bloqueo_d;
   logic                  we_q, we_d;
   logic [ANCHO_DIR-1:0]  dir_q, dir_d;
   logic [ANCHO_DATO-1:0] dato_w_q, dato_w_d;
   logic [ANCHO_DATO-1:0] cpu_dato_r_q, cpu_dato_r_d;
   logic [ANCHO_DATO-1:0] io_dato_r_q, io_dato_r_d;

   logic                  io_elegible;
   logic                  hay_peticion;
   logic                  gana;

   // bloqueo_q is armed by every CPU grant; the lock only bites while the CPU
   // keeps cpu_bloqueo high, and the first REPOSO sample of cpu_bloqueo=0 disarms it.
   always_comb begin : arbitraje
      io_elegible  = io_req & ~(bloqueo_q & cpu_bloqueo);
      hay_peticion = cpu_req | io_elegible;
`ifdef ARBITRO_ROUND_ROBIN_EN
      if (cpu_req && io_elegible) begin
         gana = ~ganador_q;
      end else begin
         gana = io_elegible ? GANA_IO : GANA_CPU;
      end
`else
      gana = cpu_req ? GANA_CPU : GANA_IO;
`endif
   end

   always_comb begin : siguiente
      estado_d     = estado_q;
      contador_d   = contador_q;
      ganador_d    = ganador_q;
      bloqueo_d    = bloqueo_q;
      we_d         = we_q;
      dir_d        = dir_q;
      dato_w_d     = dato_w_q;
      cpu_dato_r_d = cpu_dato_r_q;
      io_dato_r_d  = io_dato_r_q;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      cpu_listo    = 1'b0;
      io_listo     = 1'b0;

      case (estado_q)
         REPOSO: begin
            if (hay_peticion) begin
               estado_d   = ACCESO;
               contador_d = CONTADOR_INI;
               ganador_d  = gana;
               bloqueo_d  = (gana == GANA_CPU);
               if (gana == GANA_CPU) begin
                  we_d     = cpu_we;
                  dir_d    = cpu_dir;
                  dato_w_d = cpu_dato_w;
               end else begin
                  we_d     = io_we;
                  dir_d    = io_dir;
                  dato_w_d = io_dato_w;
               end
            end else if (!cpu_bloqueo) begin
               bloqueo_d = 1'b0;
            end
         end

         ACCESO: begin
            mem_en = 1'b1;
            mem_we = we_q;
            if (contador_q == 4'd0) begin
               estado_d = FIN;
               if (!we_q) begin
                  if (ganador_q == GANA_CPU) begin
                     cpu_dato_r_d = mem_dato_r;
                  end else begin
                     io_dato_r_d = mem_dato_r;
                  end
               end
            end else begin
               contador_d = contador_q - 4'd1;
            end
         end

         FIN: begin
            cpu_listo = (ganador_q == GANA_CPU);
            io_listo  = (ganador_q == GANA_IO);
            estado_d  = REPOSO;
         end

         default: begin
            estado_d = REPOSO;
         end
      endcase
   end

   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         estado_q     <= REPOSO;
         contador_q   <= 4'd0;
         ganador_q    <= GANA_CPU;
         bloqueo_q    <= 1'b0;
         we_q         <= 1'b0;
         dir_q        <= '0;
         dato_w_q     <= '0;
         cpu_dato_r_q <= '0;
         io_dato_r_q  <= '0;
      end else begin
         estado_q     <= estado_d;
         contador_q   <= contador_d;
         ganador_q    <= ganador_d;
         bloqueo_q    <= bloqueo_d;
         we_q         <= we_d;
         dir_q        <= dir_d;
         dato_w_q     <= dato_w_d;
         cpu_dato_r_q <= cpu_dato_r_d;
         io_dato_r_q  <= io_dato_r_d;
      end
   end

   assign mem_dir    = dir_q;
   assign mem_dato_w = dato_w_q;
   assign cpu_dato_r = cpu_dato_r_q;
   assign io_dato_r  = io_dato_r_q;
   assign ocupado    = (estado_q != REPOSO);

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb/tb_arbitro_memoria.sv - self-checking bench for arbitro_memoria

module tb_arbitro_memoria;

   localparam int L = 2;
`ifdef ARBITRO_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        Reloj = 1'b0;
   logic        Reiniciar;
   logic        cpu_req, cpu_we, cpu_bloqueo, cpu_listo;
   logic [15:0] cpu_dir, cpu_dato_w, cpu_dato_r;
   logic        io_req, io_we, io_listo;
   logic [15:0] io_dir, io_dato_w, io_dato_r;
   logic        mem_en, mem_we, ocupado;
   logic [15:0] mem_dir, mem_dato_w, mem_dato_r;

   always #5 Reloj = ~Reloj;

   arbitro_memoria #(.ANCHO_DIR(16), .ANCHO_DATO(16), .LATENCIA(L)) dut (
      .Reloj(Reloj), .Reiniciar(Reiniciar),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_dir(cpu_dir), .cpu_dato_w(cpu_dato_w),
      .cpu_bloqueo(cpu_bloqueo), .cpu_dato_r(cpu_dato_r), .cpu_listo(cpu_listo),
      .io_req(io_req), .io_we(io_we), .io_dir(io_dir), .io_dato_w(io_dato_w),
      .io_dato_r(io_dato_r), .io_listo(io_listo),
      .mem_en(mem_en), .mem_we(mem_we), .mem_dir(mem_dir), .mem_dato_w(mem_dato_w),
      .mem_dato_r(mem_dato_r), .ocupado(ocupado)
   );

   // environment memory (driven by DUT writes) and reference memory (model)
   logic [15:0] env_mem [16];
   logic [15:0] ref_mem [16];
   assign mem_dato_r = env_mem[mem_dir[3:0]];

   int n_chk = 0, n_pass = 0;
   int cyc = 0, en_cnt = 0, cl_cyc = -1, il_cyc = -1;
   bit log_q [$];

   // requester records
   bit          c_act, c_we, i_act, i_we;
   logic [15:0] c_dir, c_dat, i_dir, i_dat;

   // transaction-level model
   bit          m_busy, m_own, m_last, m_lock, m_we;
   int          m_age;
   logic [15:0] m_dir, m_dat, m_cpu_r, m_io_r;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic modelo_reset();
      m_busy = 0; m_age = 0; m_own = 0; m_last = 0; m_lock = 0;
      m_cpu_r = '0; m_io_r = '0;
   endtask

   task automatic ciclo(input bit aleatorio);
      bit exp_en, exp_cl, exp_il, fin_c, fin_i, io_ok, w;
      exp_en = m_busy && (m_age <= L);
      exp_cl = m_busy && (m_age == L + 1) && !m_own;
      exp_il = m_busy && (m_age == L + 1) && m_own;
      check_eq("mem_en", mem_en, exp_en);
      if (exp_en) begin
         check_eq("mem_we", mem_we, m_we);
         check_eq("mem_dir", mem_dir, m_dir);
         if (m_we) check_eq("mem_dato_w", mem_dato_w, m_dat);
      end else begin
         check_eq("mem_we_idle", mem_we, 1'b0);
      end
      check_eq("cpu_listo", cpu_listo, exp_cl);
      check_eq("io_listo", io_listo, exp_il);
      check_eq("ocupado", ocupado, m_busy);
      check_eq("cpu_dato_r", cpu_dato_r, m_cpu_r);
      check_eq("io_dato_r", io_dato_r, m_io_r);
      if (!Reiniciar) begin
         check_eq("rst_mem_dir", mem_dir, 16'h0);
         check_eq("rst_mem_dato_w", mem_dato_w, 16'h0);
      end

      if (mem_en && mem_we) env_mem[mem_dir[3:0]] = mem_dato_w;
      if (mem_en) en_cnt++;
      if (cpu_listo) cl_cyc = cyc;
      if (io_listo) il_cyc = cyc;

      fin_c = 0; fin_i = 0;
      if (exp_cl) begin c_act = 0; cpu_req = 0; log_q.push_back(1'b0); fin_c = 1; end
      if (exp_il) begin i_act = 0; io_req = 0; log_q.push_back(1'b1); fin_i = 1; end

      if (aleatorio) begin
         if (!c_act && !fin_c && $urandom_range(0, 3) == 0) begin
            c_act = 1; c_we = 1'($urandom_range(0, 1));
            c_dir = 16'($urandom); c_dat = 16'($urandom);
            cpu_bloqueo = ($urandom_range(0, 2) == 0);
         end else if (!c_act && $urandom_range(0, 1) == 0) begin
            cpu_bloqueo = ~cpu_bloqueo;
         end
         if (!i_act && !fin_i && $urandom_range(0, 2) == 0) begin
            i_act = 1; i_we = 1'($urandom_range(0, 1));
            i_dir = 16'($urandom); i_dat = 16'($urandom);
         end
      end

      // a granted requester's pins are free to wander; the latched copy must win
      if (!(m_busy && !m_own)) begin
         cpu_req = c_act; cpu_we = c_we; cpu_dir = c_dir; cpu_dato_w = c_dat;
      end else if (aleatorio && $urandom_range(0, 1) == 0) begin
         cpu_we = 1'($urandom_range(0, 1)); cpu_dir = 16'($urandom); cpu_dato_w = 16'($urandom);
      end
      if (!(m_busy && m_own)) begin
         io_req = i_act; io_we = i_we; io_dir = i_dir; io_dato_w = i_dat;
      end else if (aleatorio && $urandom_range(0, 1) == 0) begin
         io_we = 1'($urandom_range(0, 1)); io_dir = 16'($urandom); io_dato_w = 16'($urandom);
      end

      // model step for the coming edge
      if (!Reiniciar) begin
         modelo_reset();
      end else if (!m_busy) begin
         io_ok = io_req && !(m_lock && cpu_bloqueo);
         w = 1'b0;
         if (cpu_req && io_ok) w = RR ? !m_last : 1'b0;
         else if (io_ok) w = 1'b1;
         if (cpu_req || io_ok) begin
            m_busy = 1; m_age = 1; m_own = w; m_last = w; m_lock = !w;
            m_we  = w ? io_we : cpu_we;
            m_dir = w ? io_dir : cpu_dir;
            m_dat = w ? io_dato_w : cpu_dato_w;
         end else if (!cpu_bloqueo) begin
            m_lock = 0;
         end
      end else begin
         if (m_age == L) begin
            if (m_we) ref_mem[m_dir[3:0]] = m_dat;
            else if (m_own) m_io_r = ref_mem[m_dir[3:0]];
            else m_cpu_r = ref_mem[m_dir[3:0]];
         end
         m_age++;
         if (m_age == L + 2) m_busy = 0;
      end

      cyc++;
      @(posedge Reloj);
      @(negedge Reloj);
   endtask

   task automatic wait_done(input int n, input string tag);
      int k = 0;
      while (log_q.size() < n && k < 60) begin
         ciclo(1'b0);
         k++;
      end
      check_eq(tag, log_q.size(), n);
   endtask

   initial begin
      int t0, k;
      Reiniciar = 0;
      cpu_req = 0; cpu_we = 0; cpu_dir = 0; cpu_dato_w = 0; cpu_bloqueo = 0;
      io_req = 0; io_we = 0; io_dir = 0; io_dato_w = 0;
      c_act = 0; c_we = 0; c_dir = 0; c_dat = 0;
      i_act = 0; i_we = 0; i_dir = 0; i_dat = 0;
      m_we = 0; m_dir = 0; m_dat = 0;
      modelo_reset();
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = 16'(i * 16'h1357 + 16'h0A0A);
         ref_mem[i] = env_mem[i];
      end
      env_mem[0] = 16'hBEEF; ref_mem[0] = 16'hBEEF;

      @(negedge Reloj);
      ciclo(1'b0); ciclo(1'b0);
      Reiniciar = 1;
      ciclo(1'b0);

      // CPU read, memory returns 0xBEEF
      log_q.delete(); en_cnt = 0; t0 = cyc; cl_cyc = -1; il_cyc = -1;
      c_act = 1; c_we = 0; c_dir = 16'h0010; c_dat = 16'h0;
      wait_done(1, "t1_done");
      check_eq("t1_winner", log_q[0], 1'b0);
      check_eq("t1_latency", cl_cyc - t0, L + 1);
      check_eq("t1_en_cycles", en_cnt, L);
      check_eq("t1_dato", cpu_dato_r, 16'hBEEF);
      check_eq("t1_no_io_listo", il_cyc, -1);
      ciclo(1'b0);

      // I/O write alone
      log_q.delete(); en_cnt = 0; t0 = cyc;
      i_act = 1; i_we = 1; i_dir = 16'h00FF; i_dat = 16'h1234;
      wait_done(1, "t2_done");
      check_eq("t2_winner", log_q[0], 1'b1);
      check_eq("t2_latency", il_cyc - t0, L + 1);
      check_eq("t2_en_cycles", en_cnt, L);
      check_eq("t2_io_r_kept", io_dato_r, 16'h0);
      check_eq("t2_mem_written", env_mem[15], 16'h1234);
      ciclo(1'b0);

      // CPU write, then both requesters together
      log_q.delete();
      c_act = 1; c_we = 1; c_dir = 16'h0027; c_dat = 16'h5A5A;
      wait_done(1, "t3a_done");
      ciclo(1'b0);
      log_q.delete();
      c_act = 1; c_we = 0; c_dir = 16'h0027;
      i_act = 1; i_we = 0; i_dir = 16'h00FF;
      wait_done(2, "t3_done");
      check_eq("t3_first", log_q[0], RR ? 1'b1 : 1'b0);
      check_eq("t3_second", log_q[1], RR ? 1'b0 : 1'b1);
      check_eq("t3_cpu_r", cpu_dato_r, 16'h5A5A);
      check_eq("t3_io_r", io_dato_r, 16'h1234);
      ciclo(1'b0);

      // lock: I/O waits through a CPU read-modify-write
      log_q.delete();
      cpu_bloqueo = 1; c_act = 1; c_we = 0; c_dir = 16'h0041;
      ciclo(1'b0);
      i_act = 1; i_we = 1; i_dir = 16'h0042; i_dat = 16'h7777;
      wait_done(1, "t4_read_done");
      c_act = 1; c_we = 1; c_dir = 16'h0043; c_dat = 16'h3C3C;
      wait_done(2, "t4_write_done");
      cpu_bloqueo = 0;
      wait_done(3, "t4_io_done");
      check_eq("t4_order0", log_q[0], 1'b0);
      check_eq("t4_order1", log_q[1], 1'b0);
      check_eq("t4_order2", log_q[2], 1'b1);
      ciclo(1'b0);

      // asynchronous reset in the middle of an access
      log_q.delete();
      c_act = 1; c_we = 0; c_dir = 16'h0003;
      ciclo(1'b0);
      Reiniciar = 0;
      #1;
      check_eq("t5_mem_en_async", mem_en, 1'b0);
      check_eq("t5_ocupado_async", ocupado, 1'b0);
      check_eq("t5_listo_async", cpu_listo, 1'b0);
      modelo_reset();
      c_act = 0; cpu_req = 0;
      ciclo(1'b0); ciclo(1'b0); ciclo(1'b0);
      Reiniciar = 1;
      check_eq("t5_no_listo", log_q.size(), 0);
      c_act = 1; c_we = 0; c_dir = 16'h0007;
      wait_done(1, "t5_after_done");
      check_eq("t5_after_dato", cpu_dato_r, 16'h5A5A);
      ciclo(1'b0);

      // address change after the grant is ignored
      log_q.delete();
      c_act = 1; c_we = 0; c_dir = 16'h0001;
      ciclo(1'b0);
      cpu_dir = 16'h0002;
      ciclo(1'b0);
      check_eq("t6_mem_dir", mem_dir, 16'h0001);
      wait_done(1, "t6_done");
      ciclo(1'b0);

      // randomized traffic
      log_q.delete();
      repeat (3000) ciclo(1'b1);

      // drain
      k = 0;
      while (k < 200 && (c_act || i_act || m_busy)) begin
         if (!c_act) cpu_bloqueo = 0;
         ciclo(1'b0);
         k++;
      end
      check_eq("drain", {29'h0, c_act, i_act, m_busy}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
